// File: rtl/gtech_pkg.sv
// Shared OP encodings and elaboration helpers for the GTECH reduction family.
// Pure package: no logic, no latency, no flow control.
package gtech_pkg;

  typedef enum logic [2:0] {
    GTECH_OP_AND    = 3'd0,
    GTECH_OP_OR     = 3'd1,
    GTECH_OP_XOR    = 3'd2,
    GTECH_OP_XOR_R  = 3'd3,
    GTECH_OP_NAND   = 3'd4,
    GTECH_OP_NOR    = 3'd5,
    GTECH_OP_XNOR   = 3'd6,
    GTECH_OP_XNOR_R = 3'd7
  } gtech_op_e;

  localparam logic [1:0] GTECH_BASE_AND = 2'd0;
  localparam logic [1:0] GTECH_BASE_OR  = 2'd1;

  // Signal count at tree level lvl (level 0 is the raw operand).
  function automatic int gtech_level_width(input int width, input int leaf, input int lvl);
    int w;
    w = width;
    for (int i = 0; i < lvl; i++) w = (w + leaf - 1) / leaf;
    return w;
  endfunction

  function automatic int gtech_num_levels(input int width, input int leaf);
    int s;
    int w;
    s = 0;
    w = width;
    while (w > 1) begin
      w = (w + leaf - 1) / leaf;
      s++;
    end
    return (s < 1) ? 1 : s;
  endfunction

  // Identity of the base function: 1 for AND, 0 for OR/XOR.
  function automatic logic gtech_identity(input logic [1:0] op);
    return (op == GTECH_BASE_AND);
  endfunction

endpackage

// File: rtl/gtech_reduce_node.sv
// One LEAF-input tree node computing the un-inverted base function.
// Purely combinational; no flow control.
module gtech_reduce_node
  import gtech_pkg::*;
#(
  parameter int LEAF = 4
) (
  input  logic [1:0]      op_i,
  input  logic [LEAF-1:0] a_i,
  output logic            z_o
);

  always_comb begin
    case (op_i)
      GTECH_BASE_AND: z_o = &a_i;
      GTECH_BASE_OR:  z_o = |a_i;
      default:        z_o = ^a_i;
    endcase
  end

endmodule

// File: rtl/gtech_reduce_pipe.sv
// Pipelined WIDTH-input AND/OR/XOR reduction (+ final inversion) over a LEAF-ary tree; latency S cycles with
// GTECH_REDUCE_STAGE_REG_EN, else 1. Bubble-free valid/ready: IN_READY is combinational from OUT_READY.
module gtech_reduce_pipe
  import gtech_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LEAF  = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] A,
  input  logic [2:0]       OP,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic             Z,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  localparam int S = gtech_num_levels(WIDTH, LEAF);
`ifdef GTECH_REDUCE_STAGE_REG_EN
  localparam bit STAGE_REG = 1'b1;
  localparam int NSTG      = S;
`else
  localparam bit STAGE_REG = 1'b0;
  localparam int NSTG      = 1;
`endif

  logic [NSTG-1:0] vld_q;
  logic [NSTG-1:0] adv;
  logic [NSTG-1:0] ld_vld;
  logic [2:0]      op_q  [NSTG];
  logic [2:0]      ld_op [NSTG];

  // A stage may move if any stage at or after it is empty, or the sink takes the head.
  always_comb begin
    logic go;
    go  = OUT_READY;
    adv = '0;
    for (int k = NSTG - 1; k >= 0; k--) begin
      go     = go | ~vld_q[k];
      adv[k] = go;
    end
  end

  always_comb begin
    ld_vld = '0;
    for (int k = 0; k < NSTG; k++) ld_op[k] = 3'd0;
    ld_vld[0] = IN_VALID;
    ld_op[0]  = OP;
    for (int k = 1; k < NSTG; k++) begin
      ld_vld[k] = vld_q[k-1];
      ld_op[k]  = op_q[k-1];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_q <= '0;
      for (int k = 0; k < NSTG; k++) op_q[k] <= 3'd0;
    end else begin
      for (int k = 0; k < NSTG; k++) begin
        if (adv[k]) begin
          vld_q[k] <= ld_vld[k];
          if (ld_vld[k]) op_q[k] <= ld_op[k];
        end
      end
    end
  end

  for (genvar l = 0; l < S; l++) begin : g_lvl
    localparam int NIN  = gtech_level_width(WIDTH, LEAF, l);
    localparam int NOUT = gtech_level_width(WIDTH, LEAF, l + 1);
    localparam int NPAD = NOUT * LEAF - NIN;
    localparam int SIDX = STAGE_REG ? l : 0;

    logic [NIN-1:0]       din;
    logic [1:0]           op;
    logic [NOUT*LEAF-1:0] pad;
    logic [NOUT-1:0]      dout;
    logic [NOUT-1:0]      lvl_o;

    if (l == 0) begin : g_src
      assign din = A;
      assign op  = OP[1:0];
    end else if (STAGE_REG) begin : g_src
      assign din = g_lvl[l-1].lvl_o;
      assign op  = op_q[l-1][1:0];
    end else begin : g_src
      assign din = g_lvl[l-1].lvl_o;
      assign op  = OP[1:0];
    end

    if (NPAD > 0) begin : g_pad
      assign pad = {{NPAD{gtech_identity(op)}}, din};
    end else begin : g_pad
      assign pad = din;
    end

    for (genvar n = 0; n < NOUT; n++) begin : g_node
      gtech_reduce_node #(.LEAF(LEAF)) u_node (
        .op_i (op),
        .a_i  (pad[n*LEAF +: LEAF]),
        .z_o  (dout[n])
      );
    end

    if (STAGE_REG || l == S - 1) begin : g_reg
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) lvl_o <= '0;
        else if (adv[SIDX] && ld_vld[SIDX]) lvl_o <= dout;
      end
    end else begin : g_reg
      assign lvl_o = dout;
    end
  end

  // Inversion uses the OP that travelled with the item into the last stage.
  assign IN_READY  = adv[0];
  assign OUT_VALID = vld_q[NSTG-1];
  assign Z         = g_lvl[S-1].lvl_o[0] ^ op_q[NSTG-1][2];

endmodule

// File: tb/tb_gtech_reduce_pipe.sv
// Randomised bench for gtech_reduce_pipe (WIDTH=16/LEAF=4 plus a WIDTH=13 padding instance),
// scored against a bit-counting reference model and an occupancy/latency model of the handshake.
module tb_gtech_reduce_pipe;

`ifdef GTECH_REDUCE_STAGE_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int CAP = LAT;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [2:0]  op;
  logic        in_vld, in_rdy, z, out_vld, out_rdy;
  logic [12:0] p_a;
  logic [2:0]  p_op;
  logic        p_iv, p_ir, p_z, p_ov, p_or;

  int   n_chk, n_err, cyc, n_pop, n_acc, first_pop, last_pop;
  logic last_z;
  bit   popped;
  logic exp_q[$];
  int   acc_q[$];

  gtech_reduce_pipe #(.WIDTH(16), .LEAF(4)) u_dut (
    .CLK(clk), .RST_N(rst_n), .A(a), .OP(op), .IN_VALID(in_vld), .IN_READY(in_rdy),
    .Z(z), .OUT_VALID(out_vld), .OUT_READY(out_rdy)
  );

  gtech_reduce_pipe #(.WIDTH(13), .LEAF(4)) u_pad (
    .CLK(clk), .RST_N(rst_n), .A(p_a), .OP(p_op), .IN_VALID(p_iv), .IN_READY(p_ir),
    .Z(p_z), .OUT_VALID(p_ov), .OUT_READY(p_or)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: count ones over the first w bits and apply the rule for the OP.
  function automatic logic ref_z(input logic [15:0] av, input logic [2:0] ov, input int w);
    int   ones;
    logic r;
    ones = 0;
    for (int i = 0; i < w; i++) ones += int'(av[i]);
    case (ov[1:0])
      2'd0:    r = (ones == w);
      2'd1:    r = (ones != 0);
      default: r = (ones % 2) == 1;
    endcase
    return r ^ ov[2];
  endfunction

  function automatic logic [15:0] rand_a();
    case ($urandom_range(0, 3))
      0:       return 16'hFFFF;
      1:       return 16'h0000;
      2:       return 16'h0001 << $urandom_range(0, 15);
      default: return 16'($urandom);
    endcase
  endfunction

  // One cycle: drive after negedge, score what the coming posedge will transfer.
  task automatic step(input logic iv, input logic [15:0] av, input logic [2:0] ov, input logic ordy);
    logic exp_ov;
    @(negedge clk);
    in_vld = iv; a = av; op = ov; out_rdy = ordy;
    #1;
    popped = 0;
    check_val("in_ready", in_rdy, (exp_q.size() < CAP) || ordy);
    exp_ov = (exp_q.size() > 0) && (cyc - acc_q[0] >= LAT);
    check_val("out_valid", out_vld, exp_ov);
    if (out_vld && exp_q.size() > 0) check_val("z", z, exp_q[0]);
    if (out_vld && ordy && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      void'(acc_q.pop_front());
      last_z = z;
      popped = 1;
      if (n_pop == 0) first_pop = cyc;
      last_pop = cyc;
      n_pop++;
    end
    if (iv && in_rdy) begin
      exp_q.push_back(ref_z(av, ov, 16));
      acc_q.push_back(cyc);
      n_acc++;
    end
    cyc++;
  endtask

  task automatic sweep(input logic [15:0] av, input logic [2:0] ov, input logic exp, input string tag);
    int n;
    step(1'b1, av, ov, 1'b1);
    n = 0;
    popped = 0;
    while (!popped && n < 10) begin
      step(1'b0, 16'h0, 3'd0, 1'b1);
      n++;
    end
    check_val({tag, "_lat"}, n, LAT);
    check_val({tag, "_z"}, last_z, exp);
  endtask

  task automatic pad_check(input logic [12:0] av, input logic [2:0] ov, input logic exp, input string tag);
    int n;
    @(negedge clk);
    p_iv = 1'b1; p_a = av; p_op = ov; p_or = 1'b1;
    #1;
    check_val({tag, "_rdy"}, p_ir, 1);
    @(negedge clk);
    p_iv = 1'b0;
    n = 1;
    while (!p_ov && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_lat"}, n, LAT);
    check_val({tag, "_z"}, p_z, exp);
  endtask

  initial begin
    logic hz;
    logic [12:0] ra;
    logic [2:0]  rop;
    n_chk = 0; n_err = 0; cyc = 0; n_pop = 0; n_acc = 0; first_pop = 0; last_pop = 0;
    last_z = 1'b0; popped = 0;
    rst_n = 1'b0; in_vld = 1'b0; a = '0; op = '0; out_rdy = 1'b0;
    p_a = '0; p_op = '0; p_iv = 1'b0; p_or = 1'b1;

    // Reset held with random inputs
    repeat (4) begin
      @(negedge clk);
      a = 16'($urandom); op = 3'($urandom_range(0, 7));
      in_vld = 1'($urandom_range(0, 1)); out_rdy = 1'($urandom_range(0, 1));
      #1;
      check_val("rst_out_valid", out_vld, 0);
      check_val("rst_z", z, 0);
      check_val("rst_pad_out_valid", p_ov, 0);
    end
    @(negedge clk);
    in_vld = 1'b0; out_rdy = 1'b0;
    rst_n = 1'b1;
    #1;
    check_val("rst_in_ready", in_rdy, 1);

    // Functional sweep with latency
    sweep(16'hFFFF, 3'd0, 1'b1, "and_ones");
    sweep(16'hFFFF, 3'd4, 1'b0, "nand_ones");
    sweep(16'h0001, 3'd1, 1'b1, "or_one");
    sweep(16'h0001, 3'd5, 1'b0, "nor_one");
    sweep(16'h0007, 3'd2, 1'b1, "xor_three");
    sweep(16'h0007, 3'd6, 1'b0, "xnor_three");
    sweep(16'hFFFE, 3'd0, 1'b0, "and_missing");
    sweep(16'h0000, 3'd5, 1'b1, "nor_zero");
    sweep(16'h8001, 3'd3, 1'b0, "xor_rsvd");
    sweep(16'h8000, 3'd7, 1'b0, "xnor_rsvd");

    // Streaming: back-to-back, OP cycling
    n_pop = 0;
    for (int i = 0; i < 64; i++) step(1'b1, rand_a(), 3'(i % 7), 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 16'h0, 3'd0, 1'b1);
    check_val("stream_count", n_pop, 64);
    check_val("stream_gapless", last_pop - first_pop, 63);

    // Backpressure mid-stream
    n_pop = 0; n_acc = 0;
    for (int i = 0; i < 8; i++) step(1'b1, rand_a(), 3'($urandom_range(0, 7)), 1'b1);
    hz = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, rand_a(), 3'($urandom_range(0, 7)), 1'b0);
      if (i > 0) begin
        check_val("bp_z_stable", z, hz);
        check_val("bp_ov_stable", out_vld, 1);
      end
      hz = z;
    end
    check_val("bp_in_ready_low", in_rdy, 0);
    for (int i = 0; i < 8; i++) step(1'b1, rand_a(), 3'($urandom_range(0, 7)), 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 16'h0, 3'd0, 1'b1);
    check_val("bp_none_lost", n_pop, n_acc);

    // Random valid and ready
    n_pop = 0; n_acc = 0;
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), rand_a(), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0));
    for (int i = 0; i < 8; i++) step(1'b0, 16'h0, 3'd0, 1'b1);
    check_val("rand_none_lost", n_pop, n_acc);

    // Padding on the 13-bit instance
    pad_check(13'h1FFF, 3'd0, 1'b1, "pad_and");
    pad_check(13'h1FFF, 3'd2, 1'b1, "pad_xor");
    pad_check(13'h1FFF, 3'd4, 1'b0, "pad_nand");
    pad_check(13'h0000, 3'd1, 1'b0, "pad_or");
    for (int i = 0; i < 6; i++) begin
      ra  = 13'($urandom);
      rop = 3'($urandom_range(0, 7));
      if (i < 2) ra = 13'h1FFF;
      pad_check(ra, rop, ref_z({3'b000, ra}, rop, 13), "pad_rand");
    end

    // Mid-stream reset with items in flight
    step(1'b1, 16'hFFFF, 3'd0, 1'b0);
    step(1'b1, 16'h0001, 3'd1, 1'b0);
    step(1'b0, 16'h0000, 3'd0, 1'b0);
    check_val("mrst_pre_out_valid", out_vld, 1);
    @(negedge clk);
    in_vld = 1'b0; out_rdy = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mrst_out_valid", out_vld, 0);
    check_val("mrst_z", z, 0);
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 3'd0, 1'b1);
    n_pop = 0; n_acc = 0;
    for (int i = 0; i < 10; i++) step(1'b1, rand_a(), 3'($urandom_range(0, 7)), 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 3'd0, 1'b1);
    check_val("post_rst_count", n_pop, n_acc);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
